traffic_phase_scheduler: RTL and testbench

//  Four-way junction phase controller fed by the per-road sensor averaging units.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/traffic_phase_scheduler_if.sv | 26 ++
 rtl/traffic_phase_scheduler_road_select.sv | 59 +++++
 rtl/traffic_phase_scheduler.sv | 157 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the four-way junction phase scheduler:
// road codes, FSM state encoding, lamp width and a one-hot helper.
package traffic_pkg;

    localparam int LAMP_W    = 4;
    localparam int NUM_ROADS = 4;

    // Road codes; also the bit index of each road in the lamp vectors.
    localparam logic [1:0] ROAD_N = 2'd0;
    localparam logic [1:0] ROAD_E = 2'd1;
    localparam logic [1:0] ROAD_S = 2'd2;
    localparam logic [1:0] ROAD_W = 2'd3;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_SELECT  = 2'd1,
        ST_GREEN   = 2'd2,
        ST_YELLOW  = 2'd3
    } state_t;

    // Lamp vector with only the bit of the given road set.
    function automatic logic [LAMP_W-1:0] road_onehot(input logic [1:0] road);
        road_onehot = {{(LAMP_W-1){1'b0}}, 1'b1} << road;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Bundle between the sensor averaging units and the phase scheduler:
// four traffic averages in, served road and lamp drives out.
interface traffic_phase_scheduler_if;

    logic [7:0] avg_n;
    logic [7:0] avg_e;
    logic [7:0] avg_s;
    logic [7:0] avg_w;
    logic [1:0] next_road;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       phase_busy;

    // Sensor side: supplies averages, observes the scheduler.
    modport master (
        output avg_n, avg_e, avg_s, avg_w,
        input  next_road, green, yellow, phase_busy
    );

    // Scheduler side.
    modport slave (
        input  avg_n, avg_e, avg_s, avg_w,
        output next_road, green, yellow, phase_busy
    );

endinterface

// File: rtl/traffic_phase_scheduler_road_select.sv
// Combinational winner selection for the next green phase.
// Candidates are the three roads other than the last one served, scanned in
// round-robin order starting just after it. A starved road (skip at its
// ceiling) wins outright; otherwise the highest average wins, with ties (and
// the all-zero case) going to the earliest road in the scan.
module road_select
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 20,
    parameter int SCALE_SHIFT = 4,
    parameter int MAX_SKIP    = 3,
    parameter int SKIP_W      = 2
) (
    input  logic [NUM_ROADS-1:0][7:0]        avg_i,
    input  logic [NUM_ROADS-1:0][SKIP_W-1:0] skip_i,
    input  logic [1:0]                       last_road_i,
    output logic [1:0]                       winner_o,
    output logic [8:0]                       green_len_o
);

    logic [1:0] cand_s;
    logic       force_hit_s;
    logic       forced_found_s;
    logic [1:0] forced_road_s;
    logic [1:0] best_road_s;
    logic [7:0] best_avg_s;
    logic [1:0] winner_s;
    logic [8:0] sum_s;

    // Scan candidates in round-robin order, tracking first starved road and best average.
    always_comb begin
        cand_s         = last_road_i + 2'd1;
        force_hit_s    = 1'b0;
        forced_found_s = 1'b0;
        forced_road_s  = last_road_i + 2'd1;
        best_road_s    = last_road_i + 2'd1;
        best_avg_s     = avg_i[last_road_i + 2'd1];
        for (int k = 1; k < NUM_ROADS; k++) begin
            cand_s         = last_road_i + 2'(k);
            force_hit_s    = !forced_found_s && (skip_i[cand_s] == SKIP_W'(MAX_SKIP));
            forced_road_s  = force_hit_s ? cand_s : forced_road_s;
            forced_found_s = forced_found_s | force_hit_s;
            // Strictly greater keeps the earlier road on a tie.
            best_road_s    = (avg_i[cand_s] > best_avg_s) ? cand_s : best_road_s;
            best_avg_s     = (avg_i[cand_s] > best_avg_s) ? avg_i[cand_s] : best_avg_s;
        end
        winner_s = forced_found_s ? forced_road_s : best_road_s;
    end

    // Size the green time from the winner's average, clamped to the maximum.
    always_comb begin
        sum_s       = 9'(MIN_GREEN) + {1'b0, (avg_i[winner_s] >> SCALE_SHIFT)};
        green_len_o = (sum_s > 9'(MAX_GREEN)) ? 9'(MAX_GREEN) : sum_s;
    end

    assign winner_o = winner_s;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-way junction phase controller. A free-running prescaler produces
// timing ticks; the phase FSM walks ALL_RED -> SELECT -> GREEN -> YELLOW and
// drives registered lamp outputs. Per-road skip counters feed the
// anti-starvation rule in road_select.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 10,
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 20,
    parameter int SCALE_SHIFT = 4,
    parameter int YELLOW_T    = 2,
    parameter int ALLRED_T    = 1,
    parameter int MAX_SKIP    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    traffic_phase_scheduler_if.slave  bus_if
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SKIP_W  = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;
    localparam int TIMER_W = 9;

    state_t                          state_q;
    logic [TIMER_W-1:0]              timer_q;
    logic [PRESC_W-1:0]              presc_q;
    logic [1:0]                      next_road_q;
    logic [LAMP_W-1:0]               green_q;
    logic [LAMP_W-1:0]               yellow_q;
    logic                            busy_q;
    logic [1:0]                      last_road_q;
    logic [NUM_ROADS-1:0][SKIP_W-1:0] skip_q;
    logic [NUM_ROADS-1:0][SKIP_W-1:0] skip_d;

    logic                            tick_s;
    logic [NUM_ROADS-1:0][7:0]       avg_s;
    logic [1:0]                      winner_s;
    logic [8:0]                      green_len_s;

    assign tick_s = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign avg_s  = {bus_if.avg_w, bus_if.avg_s, bus_if.avg_e, bus_if.avg_n};

    road_select #(
        .MIN_GREEN   (MIN_GREEN),
        .MAX_GREEN   (MAX_GREEN),
        .SCALE_SHIFT (SCALE_SHIFT),
        .MAX_SKIP    (MAX_SKIP),
        .SKIP_W      (SKIP_W)
    ) u_road_select (
        .avg_i       (avg_s),
        .skip_i      (skip_q),
        .last_road_i (last_road_q),
        .winner_o    (winner_s),
        .green_len_o (green_len_s)
    );

    // Skip counters after a SELECT: winner clears, other candidates age (saturating).
    always_comb begin
        skip_d = skip_q;
        for (int r = 0; r < NUM_ROADS; r++) begin
            if (2'(r) == winner_s) begin
                skip_d[r] = '0;
            end else if (2'(r) == last_road_q) begin
                skip_d[r] = skip_q[r];
            end else if (skip_q[r] == SKIP_W'(MAX_SKIP)) begin
                skip_d[r] = skip_q[r];
            end else begin
                skip_d[r] = skip_q[r] + SKIP_W'(1);
            end
        end
    end

    // Free-running tick prescaler, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick_s) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    // Phase FSM with phase timer, road bookkeeping and registered lamp outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ALL_RED;
            timer_q     <= TIMER_W'(ALLRED_T);
            next_road_q <= ROAD_N;
            green_q     <= '0;
            yellow_q    <= '0;
            busy_q      <= 1'b0;
            last_road_q <= ROAD_W;
            skip_q      <= '0;
        end else begin
            case (state_q)
                ST_ALL_RED: begin
                    if (tick_s) begin
                        if (timer_q == TIMER_W'(1)) begin
                            state_q <= ST_SELECT;
                        end else begin
                            timer_q <= timer_q - TIMER_W'(1);
                        end
                    end
                end
                ST_SELECT: begin
                    // Averages are sampled only here; later changes do not resize green.
                    next_road_q <= winner_s;
                    last_road_q <= winner_s;
                    skip_q      <= skip_d;
                    timer_q     <= green_len_s;
                    green_q     <= road_onehot(winner_s);
                    busy_q      <= 1'b1;
                    state_q     <= ST_GREEN;
                end
                ST_GREEN: begin
                    if (tick_s) begin
                        if (timer_q == TIMER_W'(1)) begin
                            timer_q  <= TIMER_W'(YELLOW_T);
                            green_q  <= '0;
                            yellow_q <= road_onehot(next_road_q);
                            state_q  <= ST_YELLOW;
                        end else begin
                            timer_q <= timer_q - TIMER_W'(1);
                        end
                    end
                end
                ST_YELLOW: begin
                    if (tick_s) begin
                        if (timer_q == TIMER_W'(1)) begin
                            timer_q  <= TIMER_W'(ALLRED_T);
                            yellow_q <= '0;
                            busy_q   <= 1'b0;
                            state_q  <= ST_ALL_RED;
                        end else begin
                            timer_q <= timer_q - TIMER_W'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= ST_ALL_RED;
                    timer_q  <= TIMER_W'(ALLRED_T);
                    green_q  <= '0;
                    yellow_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.next_road  = next_road_q;
    assign bus_if.green      = green_q;
    assign bus_if.yellow     = yellow_q;
    assign bus_if.phase_busy = busy_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler. One instance uses default
// parameters, a second one MIN_GREEN=10 to exercise the MAX_GREEN clamp.
// With TICK_DIV=10 every green of G ticks lasts 10*G-1 clocks, yellow lasts
// 20 clocks, and green rises 11 clocks after the previous yellow ends
// (10 clocks all-red plus the SELECT cycle).
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] a_n, a_e, a_s, a_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler_if bus0();
    traffic_phase_scheduler_if bus1();

    assign bus0.avg_n = a_n;
    assign bus0.avg_e = a_e;
    assign bus0.avg_s = a_s;
    assign bus0.avg_w = a_w;
    assign bus1.avg_n = a_n;
    assign bus1.avg_e = a_e;
    assign bus1.avg_s = a_s;
    assign bus1.avg_w = a_w;

    traffic_phase_scheduler u_dut0 (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus0)
    );

    traffic_phase_scheduler #(.MIN_GREEN(10)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus1)
    );

    logic [1:0][3:0] grn;
    logic [1:0][3:0] yel;
    logic [1:0][1:0] nr;
    logic [1:0]      bsy;

    assign grn = {bus1.green, bus0.green};
    assign yel = {bus1.yellow, bus0.yellow};
    assign nr  = {bus1.next_road, bus0.next_road};
    assign bsy = {bus1.phase_busy, bus0.phase_busy};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_avg(input logic [7:0] n, input logic [7:0] e,
                           input logic [7:0] s, input logic [7:0] w);
        a_n = n;
        a_e = e;
        a_s = s;
        a_w = w;
    endtask

    // Hold reset a few cycles, check reset outputs of both instances, release on a negedge.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_green0", 32'(grn[0]), 32'd0);
        chk("rst_yellow0", 32'(yel[0]), 32'd0);
        chk("rst_road0", 32'(nr[0]), 32'd0);
        chk("rst_busy0", 32'(bsy[0]), 32'd0);
        chk("rst_green1", 32'(grn[1]), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Follow one complete phase of instance d: expected road and green ticks.
    task automatic serve(input int d, input logic [1:0] road, input int g, input bit clr);
        logic [3:0] oh;
        int n;
        int gc;
        int yc;
        oh = 4'b0001 << road;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grn[d] == 4'd0 && n < 40);
        chk("gap_to_green", 32'(n), 32'd11);
        chk("next_road", 32'(nr[d]), 32'(road));
        chk("green_lamp", 32'(grn[d]), 32'(oh));
        chk("yellow_off_in_green", 32'(yel[d]), 32'd0);
        chk("busy_in_green", 32'(bsy[d]), 32'd1);
        if (clr) set_avg(8'd0, 8'd0, 8'd0, 8'd0);
        gc = 1;
        while (gc < 400) begin
            @(negedge clk);
            if (grn[d] != oh) break;
            gc++;
        end
        chk("green_clocks", 32'(gc), 32'(10 * g - 1));
        chk("yellow_lamp", 32'(yel[d]), 32'(oh));
        chk("green_off_in_yellow", 32'(grn[d]), 32'd0);
        chk("busy_in_yellow", 32'(bsy[d]), 32'd1);
        yc = 1;
        while (yc < 100) begin
            @(negedge clk);
            if (yel[d] != oh) break;
            yc++;
        end
        chk("yellow_clocks", 32'(yc), 32'd20);
        chk("allred_lamps", 32'({grn[d], yel[d]}), 32'd0);
        chk("busy_in_allred", 32'(bsy[d]), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state and all-zero traffic: plain round-robin, MIN_GREEN each.
        set_avg(8'd0, 8'd0, 8'd0, 8'd0);
        do_reset();
        serve(0, ROAD_N, 4, 1'b0);
        serve(0, ROAD_E, 4, 1'b0);
        serve(0, ROAD_S, 4, 1'b0);
        serve(0, ROAD_W, 4, 1'b0);
        serve(0, ROAD_N, 4, 1'b0);

        // Heavy south: S wins with 4+12 ticks; averages cleared during its green
        // must not shorten it; next pick excludes S.
        set_avg(8'd10, 8'd10, 8'd200, 8'd10);
        do_reset();
        serve(0, ROAD_S, 16, 1'b1);
        serve(0, ROAD_W, 4, 1'b0);

        // Saturated west: 4+15 ticks on default instance.
        set_avg(8'd0, 8'd0, 8'd0, 8'd255);
        do_reset();
        serve(0, ROAD_N, 4, 1'b0);
        serve(0, ROAD_W, 19, 1'b0);

        // Same traffic on MIN_GREEN=10 instance: 10+15 clamps to 20.
        do_reset();
        serve(1, ROAD_N, 10, 1'b0);
        serve(1, ROAD_W, 20, 1'b0);

        // Equal averages: strict rotation, 4+6 ticks each.
        set_avg(8'd100, 8'd100, 8'd100, 8'd100);
        do_reset();
        serve(0, ROAD_N, 10, 1'b0);
        serve(0, ROAD_E, 10, 1'b0);
        serve(0, ROAD_S, 10, 1'b0);
        serve(0, ROAD_W, 10, 1'b0);
        serve(0, ROAD_N, 10, 1'b0);

        // E and S busy, N and W light: N forced after three lost SELECTs, then W.
        set_avg(8'd5, 8'd250, 8'd250, 8'd5);
        do_reset();
        serve(0, ROAD_E, 19, 1'b0);
        serve(0, ROAD_S, 19, 1'b0);
        serve(0, ROAD_E, 19, 1'b0);
        serve(0, ROAD_N, 4, 1'b0);
        serve(0, ROAD_W, 4, 1'b0);
        serve(0, ROAD_E, 19, 1'b0);

        // Reset in the middle of E's green, between clock edges.
        set_avg(8'd100, 8'd100, 8'd100, 8'd100);
        do_reset();
        serve(0, ROAD_N, 10, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grn[0] == 4'd0 && n < 40);
        chk("mid_pre_green", 32'(grn[0]), 32'd2);
        chk("mid_pre_road", 32'(nr[0]), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_green", 32'(grn[0]), 32'd0);
        chk("mid_rst_yellow", 32'(yel[0]), 32'd0);
        chk("mid_rst_road", 32'(nr[0]), 32'd0);
        chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
        do_reset();
        serve(0, ROAD_N, 10, 1'b0);
        serve(0, ROAD_E, 10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
